data_mem_responder: RTL
=======================

Name: data_mem_responder

Overview:
- Multi-cycle data-memory responder. It is the memory end of the CPU's load/store interface: the CPU drives enable/wr/addr/data_in, and this block answers.
- Replaces the single-cycle data memory so the pipeline's stall logic can be exercised. Holds a word array and services one request at a time with fixed latency.
- Completion is signalled by a busy/data_valid handshake.

Parameters:
- ADDR_BITS, 10, log2 of word count; array holds 2^ADDR_BITS 16-bit words.
- LATENCY, 4, cycles from request acceptance to completion; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  request strobe from CPU.
- wr  input  1  1 = store, 0 = load; sampled with enable.
- addr  input  16  byte address; bit 0 ignored; word index = addr[ADDR_BITS:1]; higher bits ignored (aliasing).
- data_in  input  16  store data.
- busy  output  1  high while a request is in flight; requests are not accepted while high.
- data_valid  output  1  one-cycle pulse at completion of a load or a store.
- data_out  output  16  load result; held until the next load completes.

Behaviour:
- Reset (rst high at a rising edge):
  - busy=0, data_valid=0, data_out=16'h0000, FSM=IDLE, latency counter=0.
  - Array contents are NOT cleared.
  - Any in-flight request is aborted: a pending store is not committed and no data_valid is produced.
- Acceptance:
  - A request is accepted at rising edge k when rst=0, enable=1 and busy=0.
  - At acceptance, addr word index, wr and data_in are latched. The CPU may change inputs afterwards.
  - enable while busy=1 is ignored, not queued. The CPU must hold enable until it sees busy=0.
- FSM:
  - IDLE: on acceptance, go to WAIT, busy<=1, counter<=LATENCY-1.
  - WAIT: counter decrements each edge.
    - On the edge where counter==0, perform the access, busy<=0, data_valid<=1, return to IDLE.
    - With LATENCY=1 this is the edge after acceptance.
- Timing: accepted at edge k means busy is high for cycles k..k+LATENCY-1 and data_valid is high for exactly the cycle after edge k+LATENCY.
- Access:
  - Store: mem[idx]<=latched data_in at the completion edge. data_out is unchanged.
  - Load: data_out<=mem[idx] read at the completion edge. Array state at that edge reflects all previously completed stores.
- Back-to-back: busy is already low during the data_valid cycle, so a new request can be accepted at edge k+LATENCY+1.
  - Throughput is one request per LATENCY+1 cycles.
  - A load to the same word issued right after a store returns the stored value.
- data_valid is never high while busy=1. It never stays high for two consecutive cycles.
- rst takes priority over acceptance and completion in the same cycle.
- A store with wr=1 and data_in=X-free values only; X on inputs outside acceptance edges must not affect state.
- Assertions:
  - Counter never underflows.
  - busy=0 implies FSM=IDLE.
  - LATENCY out of range is an elaboration error.

Test Plan:
- Reset then load: hold rst 2 cycles, then enable=1, wr=0, addr=16'h0010 with default LATENCY=4 -> busy high 4 cycles, data_valid one cycle, data_out=initial contents of word 8. Before the load, data_out=0.
- Store/load pair: store data_in=16'hBEEF at addr=16'h0020, wait for data_valid, then load addr=16'h0021 -> returns 16'hBEEF, showing bit 0 is ignored. Total 10 cycles from the first acceptance to the load's data_valid.
- Input change during busy: store 16'h1234 to addr 16'h0004, then change addr/data_in to 16'h0006/16'hFFFF the cycle after acceptance -> word 2 = 16'h1234 and word 3 is unchanged.
- Enable while busy: pulse a second enable during WAIT -> ignored, only one data_valid. Holding enable continuously yields one completion every 5 cycles.
- Reset mid-store: accept a store of 16'hAAAA to word 5, assert rst at the 2nd WAIT cycle -> no data_valid, busy=0 the next cycle, a subsequent load of word 5 returns its old value, and data_out reads 0 until that load.
- Aliasing and LATENCY=1 build: load addr=16'h0802 with ADDR_BITS=10 -> same word as addr 16'h0002. With LATENCY=1, data_valid arrives 1 cycle after acceptance and busy is high for exactly 1 cycle.

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle data memory answering the CPU load/store port.
// One request at a time, fixed LATENCY, busy/data_valid completion handshake.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   enable, wr        request strobe, 1=store 0=load (sampled when idle)
//   addr              byte address; word index = addr[ADDR_BITS:1]
//   data_in           store data
//   busy              request in flight, new requests ignored
//   data_valid        one-cycle completion pulse (load or store)
//   data_out          last load result, held until the next load completes
module data_mem_responder #(
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  output logic        busy,
  output logic        data_valid,
  output logic [15:0] data_out
);

  if (LATENCY < 1 || LATENCY > 15) begin : gLatencyRange
    $error("data_mem_responder: LATENCY must be within 1..15");
  end

  typedef enum logic {
    sIdle,
    sWait
  } stateT;

  localparam int Words = 1 << ADDR_BITS;
  localparam logic [3:0] CntLoad = 4'(LATENCY - 1);

  stateT state;
  stateT stateNext;
  logic [3:0] cnt;
  logic [3:0] cntNext;
  logic accept;
  logic done;

  logic [ADDR_BITS-1:0] reqIdx;
  logic reqWr;
  logic [15:0] reqData;

  logic [15:0] mem [0:Words-1];

  // Bit 0 and the bits above the index only alias.
  logic unusedAddr;
  assign unusedAddr = ^{addr[15:ADDR_BITS+1], addr[0]};

  assign busy = (state == sWait);

  always_comb begin
    stateNext = state;
    cntNext = cnt;
    accept = 1'b0;
    done = 1'b0;
    unique case (state)
      sIdle: begin
        if (enable) begin
          accept = 1'b1;
          stateNext = sWait;
          cntNext = CntLoad;
        end
      end
      sWait: begin
        if (cnt == 4'd0) begin
          done = 1'b1;
          stateNext = sIdle;
        end else begin
          cntNext = cnt - 4'd1;
        end
      end
      default: stateNext = sIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= sIdle;
      cnt <= 4'd0;
      data_valid <= 1'b0;
      data_out <= 16'h0000;
    end else begin
      state <= stateNext;
      cnt <= cntNext;
      data_valid <= done;
      if (done && !reqWr) begin
        data_out <= mem[reqIdx];
      end
    end
  end

  // Request capture; the CPU is free to change its inputs after acceptance.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      reqIdx <= addr[ADDR_BITS:1];
      reqWr <= wr;
      reqData <= data_in;
    end
  end

  // Array is not reset; an aborted store never reaches it.
  always_ff @(posedge clk) begin
    if (!rst && done && reqWr) begin
      mem[reqIdx] <= reqData;
    end
  end

  aCntRange: assert property (
    @(posedge clk) disable iff (rst) cnt <= CntLoad);

  aNoUnderflow: assert property (
    @(posedge clk) disable iff (rst)
    (state == sWait && cnt == 4'd0) |=> state == sIdle);

  aIdleWhenFree: assert property (
    @(posedge clk) !busy |-> state == sIdle);

  aValidNotBusy: assert property (
    @(posedge clk) !(data_valid && busy));

  aValidPulse: assert property (
    @(posedge clk) data_valid |=> !data_valid);

endmodule
